// File: rtl/cam_pkg.sv
// Shared types and default geometry for the camera capture path.
package cam_pkg;

  localparam int unsigned DEF_SRC_WIDTH  = 320;
  localparam int unsigned DEF_SRC_HEIGHT = 240;
  localparam int unsigned DEF_IMG_WIDTH  = 176;
  localparam int unsigned DEF_IMG_HEIGHT = 240;

  typedef enum logic [1:0] {
    S_IDLE,
    S_VSYNC,
    S_FRAME
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into RGB565 pixels: first byte of a pair is the high half.
module cam_byte_pair
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  data,
  output logic        pix_vld,
  output logic [15:0] pix
);

  logic       phase;
  logic       phase_eff;
  logic       take;
  logic [7:0] hi;
  rgb565_t    pix_word;

  // A clear in the same cycle as a byte makes that byte the high half of a new pair.
  always_comb begin
    take      = en & byte_vld;
    phase_eff = phase & ~clr;
    pix_vld   = take & phase_eff;
    pix_word  = rgb565_t'({hi, data});
    pix       = pix_word;
  end

  // Phase toggle and high-byte latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= 1'b0;
      hi    <= '0;
    end else if (take) begin
      if (phase_eff) begin
        phase <= 1'b0;
      end else begin
        phase <= 1'b1;
        hi    <= data;
      end
    end else if (clr) begin
      phase <= 1'b0;
    end
  end

endmodule

// File: rtl/cam_frame_writer.sv
// Crops a centred window from the camera stream and writes it row-major into the frame buffer.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int unsigned SRC_WIDTH  = DEF_SRC_WIDTH,
  parameter int unsigned SRC_HEIGHT = DEF_SRC_HEIGHT,
  parameter int unsigned IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int unsigned IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int unsigned ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  capture_en,
  input  logic                  cam_vsync,
  input  logic                  cam_href,
  input  logic                  cam_byte_vld,
  input  logic [7:0]            cam_data,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] wAddr,
  output logic [15:0]           wData,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int unsigned X_OFF = (SRC_WIDTH - IMG_WIDTH) >> 1;
  localparam int unsigned Y_OFF = (SRC_HEIGHT - IMG_HEIGHT) >> 1;
  localparam int unsigned XW    = $clog2(SRC_WIDTH + 1);
  localparam int unsigned YW    = $clog2(SRC_HEIGHT + 1);
  localparam int unsigned TOTAL = IMG_WIDTH * IMG_HEIGHT;

  state_t                state;
  state_t                state_nxt;
  logic                  frame_done_nxt;
  logic                  vsync_q;
  logic                  href_q;
  logic                  vs_rise_c;
  logic                  vs_fall_c;
  logic                  href_rise_c;
  logic                  href_fall_c;
  logic                  pix_vld;
  logic [15:0]           pix;
  logic                  in_win_c;
  logic                  wr_c;
  logic [XW-1:0]         x;
  logic [YW-1:0]         y;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  full;
  logic                  line_pix;

  assign vs_rise_c   = cam_vsync & ~vsync_q;
  assign vs_fall_c   = ~cam_vsync & vsync_q;
  assign href_rise_c = cam_href & ~href_q;
  assign href_fall_c = ~cam_href & href_q;

  cam_byte_pair u_pair (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       ((state == S_FRAME) & cam_href),
    .clr      (href_rise_c | (state != S_FRAME)),
    .byte_vld (cam_byte_vld),
    .data     (cam_data),
    .pix_vld  (pix_vld),
    .pix      (pix)
  );

  // Window membership of the pixel completing this cycle; signed compare keeps zero offsets clean.
  always_comb begin
    in_win_c = (int'(x) >= int'(X_OFF)) && (int'(x) < int'(X_OFF + IMG_WIDTH)) &&
               (int'(y) >= int'(Y_OFF)) && (int'(y) < int'(Y_OFF + IMG_HEIGHT));
    wr_c     = pix_vld & in_win_c & ~full;
  end

  // Sync edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
    end
  end

  // State register and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= frame_done_nxt;
      busy       <= (state_nxt == S_FRAME);
    end
  end

  // Next state; capture_en only matters at vsync rise.
  always_comb begin
    state_nxt      = state;
    frame_done_nxt = 1'b0;
    case (state)
      S_IDLE:  if (vs_rise_c && capture_en) state_nxt = S_VSYNC;
      S_VSYNC: if (vs_fall_c) state_nxt = S_FRAME;
      S_FRAME: begin
        if (vs_rise_c) begin
          frame_done_nxt = 1'b1;
          state_nxt      = capture_en ? S_VSYNC : S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Position counters and write port; everything rewinds outside S_FRAME.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x        <= '0;
      y        <= '0;
      idx      <= '0;
      full     <= 1'b0;
      line_pix <= 1'b0;
      we       <= 1'b0;
      wAddr    <= '0;
      wData    <= '0;
    end else if (state != S_FRAME) begin
      x        <= '0;
      y        <= '0;
      idx      <= '0;
      full     <= 1'b0;
      line_pix <= 1'b0;
      we       <= 1'b0;
      wAddr    <= '0;
    end else begin
      we <= 1'b0;
      if (pix_vld) begin
        line_pix <= 1'b1;
        if (x != '1) x <= x + XW'(1);
        if (wr_c) begin
          we    <= 1'b1;
          wAddr <= idx;
          wData <= pix;
          if (idx == ADDR_WIDTH'(TOTAL - 1)) full <= 1'b1;
          else                               idx  <= idx + ADDR_WIDTH'(1);
        end
      end
      if (href_fall_c && line_pix) begin
        x        <= '0;
        line_pix <= 1'b0;
        if (y != '1) y <= y + YW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Drives one camera stream into two differently-sized writers and checks both against a frame model.
module tb_cam_frame_writer;

  localparam int GSW [2] = '{20, 8};
  localparam int GSH [2] = '{12, 4};
  localparam int GIW [2] = '{12, 4};
  localparam int GIH [2] = '{8, 2};

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        capture_en;
  logic        vsync;
  logic        href;
  logic        bvld;
  logic [7:0]  data;
  logic        we_a, we_b;
  logic [6:0]  waddr_a;
  logic [2:0]  waddr_b;
  logic [15:0] wdata_a, wdata_b;
  logic        fd_a, fd_b;
  logic        busy_a, busy_b;

  int  cyc;
  int  checks;
  int  passed;
  wr_t got [2][$];
  wr_t exp_q [2][$];
  int  fd_cnt [2];
  int  fd_exp;
  logic mid_busy [2];

  cam_frame_writer #(.SRC_WIDTH(20), .SRC_HEIGHT(12), .IMG_WIDTH(12), .IMG_HEIGHT(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(vsync), .cam_href(href),
    .cam_byte_vld(bvld), .cam_data(data), .we(we_a), .wAddr(waddr_a), .wData(wdata_a),
    .frame_done(fd_a), .busy(busy_a)
  );

  cam_frame_writer #(.SRC_WIDTH(8), .SRC_HEIGHT(4), .IMG_WIDTH(4), .IMG_HEIGHT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .capture_en(capture_en), .cam_vsync(vsync), .cam_href(href),
    .cam_byte_vld(bvld), .cam_data(data), .we(we_b), .wAddr(waddr_b), .wData(wdata_b),
    .frame_done(fd_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write and frame_done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (we_a === 1'b1) got[0].push_back({16'(waddr_a), wdata_a, 32'(cyc)});
    if (we_b === 1'b1) got[1].push_back({16'(waddr_b), wdata_b, 32'(cyc)});
    if (fd_a === 1'b1) fd_cnt[0] = fd_cnt[0] + 1;
    if (fd_b === 1'b1) fd_cnt[1] = fd_cnt[1] + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_scoreboard();
    for (int d = 0; d < 2; d++) begin
      got[d].delete();
      exp_q[d].delete();
      fd_cnt[d] = 0;
    end
    fd_exp = 0;
  endtask

  task automatic vsync_pulse();
    vsync = 1'b0;
    repeat (2) tick();
    vsync = 1'b1;
    repeat (4) tick();
  endtask

  // One frame: vsync low, lines of bytes, then vsync high. When cap is set the
  // expected writes are derived from the window rules of each geometry.
  task automatic send_frame(input int nlines, input int nbytes, input int gap_max, input bit cap,
                            input int short_line, input int mid_en, input int abort_line);
    logic [7:0] lb[$];
    int lc[$];
    int my;
    int mcnt [2];
    int nb;
    int npix;
    my = 0;
    mcnt[0] = 0;
    mcnt[1] = 0;
    vsync = 1'b0;
    repeat (3) tick();
    for (int l = 0; l < nlines; l++) begin
      if (l == nlines / 2) begin
        mid_busy[0] = busy_a;
        mid_busy[1] = busy_b;
        if (mid_en >= 0) capture_en = (mid_en != 0);
      end
      nb = (l == short_line) ? 1 : nbytes;
      lb.delete();
      lc.delete();
      href = 1'b1;
      for (int b = 0; b < nb; b++) begin
        if (l == abort_line && b == nb / 2 + 2) return;
        bvld = 1'b1;
        data = 8'($urandom);
        lb.push_back(data);
        lc.push_back(cyc);
        tick();
        bvld = 1'b0;
        if (gap_max > 0) repeat ($urandom_range(gap_max, 0)) tick();
      end
      bvld = 1'b0;
      href = 1'b0;
      npix = lb.size() / 2;
      if (cap && npix > 0) begin
        for (int i = 0; i < npix; i++) begin
          for (int d = 0; d < 2; d++) begin
            if (i >= (GSW[d] - GIW[d]) / 2 && i < (GSW[d] - GIW[d]) / 2 + GIW[d] && i < GSW[d] &&
                my >= (GSH[d] - GIH[d]) / 2 && my < (GSH[d] - GIH[d]) / 2 + GIH[d] && my < GSH[d] &&
                mcnt[d] < GIW[d] * GIH[d]) begin
              exp_q[d].push_back({16'(mcnt[d]), lb[2*i], lb[2*i+1], 32'(lc[2*i+1] + 1)});
              mcnt[d] = mcnt[d] + 1;
            end
          end
        end
        my = my + 1;
      end
      repeat (2) tick();
    end
    vsync = 1'b1;
    repeat (4) tick();
    if (cap) fd_exp = fd_exp + 1;
  endtask

  task automatic test_reset();
    clear_scoreboard();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vsync = i[0];
      tick();
    end
    checks++; if (we_a !== 1'b0 || we_b !== 1'b0) $display("FAIL reset_we got %b/%b exp 0/0", we_a, we_b); else passed++;
    checks++; if (waddr_a !== 7'd0 || waddr_b !== 3'd0) $display("FAIL reset_waddr got %0d/%0d exp 0/0", waddr_a, waddr_b); else passed++;
    checks++; if (fd_a !== 1'b0 || fd_b !== 1'b0) $display("FAIL reset_frame_done got %b/%b exp 0/0", fd_a, fd_b); else passed++;
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL reset_busy got %b/%b exp 0/0", busy_a, busy_b); else passed++;
    vsync = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    send_frame(12, 40, 0, 1'b0, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != 0) $display("FAIL idle_writes dut%0d got %0d exp 0", d, got[d].size()); else passed++;
      checks++; if (fd_cnt[d] !== 0) $display("FAIL idle_frame_done dut%0d got %0d exp 0", d, fd_cnt[d]); else passed++;
      checks++; if (mid_busy[d] !== 1'b0) $display("FAIL idle_busy dut%0d got %b exp 0", d, mid_busy[d]); else passed++;
    end
  endtask

  task automatic test_full_frame();
    clear_scoreboard();
    capture_en = 1'b1;
    vsync_pulse();
    send_frame(12, 40, 0, 1'b1, -1, -1, -1);
    checks++; if (exp_q[0].size() > 0 && got[0].size() > 0 && got[0][0].addr !== 16'd0) $display("FAIL full_first_addr got %0d exp 0", got[0][0].addr); else passed++;
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != exp_q[d].size()) $display("FAIL full_count dut%0d got %0d exp %0d", d, got[d].size(), exp_q[d].size()); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL full_write dut%0d #%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d", d, i, got[d][i].addr, got[d][i].data, got[d][i].cyc, exp_q[d][i].addr, exp_q[d][i].data, exp_q[d][i].cyc); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL full_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
      checks++; if (mid_busy[d] !== 1'b1) $display("FAIL full_busy dut%0d got %b exp 1", d, mid_busy[d]); else passed++;
    end
  endtask

  task automatic test_crop_latency();
    clear_scoreboard();
    send_frame(4, 16, 0, 1'b1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != exp_q[d].size()) $display("FAIL crop_count dut%0d got %0d exp %0d", d, got[d].size(), exp_q[d].size()); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL crop_write dut%0d #%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d", d, i, got[d][i].addr, got[d][i].data, got[d][i].cyc, exp_q[d][i].addr, exp_q[d][i].data, exp_q[d][i].cyc); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL crop_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
    end
  endtask

  task automatic test_odd_gaps();
    clear_scoreboard();
    send_frame(12, 41, 3, 1'b1, 3, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != exp_q[d].size()) $display("FAIL odd_count dut%0d got %0d exp %0d", d, got[d].size(), exp_q[d].size()); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL odd_write dut%0d #%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d", d, i, got[d][i].addr, got[d][i].data, got[d][i].cyc, exp_q[d][i].addr, exp_q[d][i].data, exp_q[d][i].cyc); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL odd_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
    end
  endtask

  task automatic test_oversize();
    clear_scoreboard();
    send_frame(14, 50, 0, 1'b1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != GIW[d] * GIH[d]) $display("FAIL over_cap dut%0d got %0d exp %0d", d, got[d].size(), GIW[d] * GIH[d]); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL over_write dut%0d #%0d got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d", d, i, got[d][i].addr, got[d][i].data, got[d][i].cyc, exp_q[d][i].addr, exp_q[d][i].data, exp_q[d][i].cyc); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL over_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
    end
  endtask

  task automatic test_arm_reset();
    logic busy_off [2];
    logic busy_on [2];
    clear_scoreboard();
    send_frame(4, 16, 0, 1'b1, -1, 0, -1);
    send_frame(4, 16, 0, 1'b0, -1, 1, -1);
    busy_off = mid_busy;
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != exp_q[d].size()) $display("FAIL arm_count dut%0d got %0d exp %0d", d, got[d].size(), exp_q[d].size()); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL arm_write dut%0d #%0d got addr=%0d data=%h exp addr=%0d data=%h", d, i, got[d][i].addr, got[d][i].data, exp_q[d][i].addr, exp_q[d][i].data); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL arm_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
      checks++; if (busy_off[d] !== 1'b0) $display("FAIL disarm_busy dut%0d got %b exp 0", d, busy_off[d]); else passed++;
    end
    send_frame(6, 16, 0, 1'b1, -1, -1, 3);
    busy_on = mid_busy;
    rst_n = 1'b0;
    #1;
    checks++; if (we_a !== 1'b0 || we_b !== 1'b0) $display("FAIL midreset_we got %b/%b exp 0/0", we_a, we_b); else passed++;
    checks++; if (waddr_a !== 7'd0 || waddr_b !== 3'd0) $display("FAIL midreset_waddr got %0d/%0d exp 0/0", waddr_a, waddr_b); else passed++;
    checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) $display("FAIL midreset_busy got %b/%b exp 0/0", busy_a, busy_b); else passed++;
    for (int d = 0; d < 2; d++) begin
      checks++; if (busy_on[d] !== 1'b1) $display("FAIL armed_busy dut%0d got %b exp 1", d, busy_on[d]); else passed++;
    end
    repeat (2) tick();
    href = 1'b0;
    rst_n = 1'b1;
    clear_scoreboard();
    repeat (2) tick();
    send_frame(2, 16, 0, 1'b0, -1, -1, -1);
    send_frame(4, 16, 0, 1'b1, -1, -1, -1);
    for (int d = 0; d < 2; d++) begin
      checks++; if (got[d].size() != exp_q[d].size()) $display("FAIL rearm_count dut%0d got %0d exp %0d", d, got[d].size(), exp_q[d].size()); else passed++;
      for (int i = 0; i < exp_q[d].size() && i < got[d].size(); i++) begin
        checks++;
        if (got[d][i] !== exp_q[d][i]) $display("FAIL rearm_write dut%0d #%0d got addr=%0d data=%h exp addr=%0d data=%h", d, i, got[d][i].addr, got[d][i].data, exp_q[d][i].addr, exp_q[d][i].data); else passed++;
      end
      checks++; if (fd_cnt[d] !== fd_exp) $display("FAIL rearm_frame_done dut%0d got %0d exp %0d", d, fd_cnt[d], fd_exp); else passed++;
    end
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b1;
    capture_en = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    bvld = 1'b0;
    data = 8'h00;
    #2;
    test_reset();
    test_full_frame();
    test_crop_latency();
    test_odd_gaps();
    test_oversize();
    test_arm_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
